writeback_queue: RTL and testbench
==================================

# writeback_queue

Buffers register-file write requests from two producers and drains them one per cycle onto the register file write port. Sits between the execute/memory stages and the 32×32 register file. It drives `RegWrite`, `RdAddr` and `RdData` and never writes register 0. It also answers decode-stage read lookups with forwarded data for writes that are accepted but not yet committed.

## Interface
- `DEPTH`, 4, number of queue entries; power of two, ≥2.
- `Clock` in 1, rising-edge clock.
- `nReset` in 1, reset: asynchronous, active-low.
- `AValid` in 1, ALU producer request.
- `AReady` out 1, ALU request accepted this edge when `AValid & AReady`.
- `AAddr` in 5, ALU destination register.
- `AData` in 32, ALU result.
- `BValid` in 1, load/mul-div producer request.
- `BReady` out 1, B request accepted this edge when `BValid & BReady`.
- `BAddr` in 5, B destination register.
- `BData` in 32, B result.
- `RegWrite` out 1, register-file write enable; registered.
- `RdAddr` out 5, register-file write address; registered.
- `RdData` out 32, register-file write data; registered.
- `RsAddr` in 5, forwarding lookup address 1.
- `RtAddr` in 5, forwarding lookup address 2.
- `RsHit` out 1, pending write to `RsAddr` exists.
- `RsFwd` out 32, youngest pending data for `RsAddr`.
- `RtHit` out 1, pending write to `RtAddr` exists.
- `RtFwd` out 32, youngest pending data for `RtAddr`.
- `Count` out $clog2(DEPTH+1), occupied queue entries, excluding the output stage.

## Operation
- Circular FIFO with head/tail pointers of $clog2(DEPTH) bits plus a count; pointers wrap modulo `DEPTH`.
- **Enqueue rules:**
  - At most one enqueue per cycle.
  - A has priority: `AReady = (Count != DEPTH)`.
  - `BReady = (Count != DEPTH) & ~AValid`.
- **Register 0 filtering:** an accepted request with address 0 is consumed (handshake completes) and discarded. It is not stored, `Count` is unchanged, and it never reaches `RegWrite`.
- **Drain:**
  - Each edge with `Count != 0`, the head entry moves into the output stage and `RegWrite` is 1 for that following cycle.
  - With `Count == 0`, `RegWrite` is 0. `RdAddr` and `RdData` hold their last values.
- **Simultaneous enqueue and dequeue:** `Count` is unchanged and both pointers advance.
  - `AReady`/`BReady` are computed from the current `Count` only; the same-cycle pop does not free space. Full means no accept.
- Entries commit strictly in acceptance order. Two writes to the same register commit oldest first.
- **Forwarding lookup** (combinational on `RsAddr`/`RtAddr`):
  - Search order is youngest valid queue entry (tail−1 backward to head), then the output stage when `RegWrite` is 1.
  - The first match wins: `Hit=1` and `Fwd` = that data.
  - Address 0 never hits.
  - On a miss, `Hit=0` and `Fwd=0`.
  - Requests being accepted in the current cycle are not searched.

## Timing
- **Reset values** (immediate and asynchronous):
  - Queue empty, `Count=0`, pointers 0.
  - `RegWrite=0`, `RdAddr=0`, `RdData=0`.
  - `AReady=1`, and `BReady=~AValid`.
  - Entry storage need not reset.
- **Latency, empty queue:** accept at edge N → `RegWrite=1` during N+1..N+2 → register file captures at edge N+2.
- **Throughput:** one commit per cycle sustained.
- **Reset mid-operation:** all pending writes are lost. No partial write is issued after `nReset` deasserts.
- `DEPTH` accepts with no drain blocking is impossible, since drain is unconditional. Full occurs only when the producers outpace the one-per-cycle drain… which cannot happen with one enqueue per cycle. `Count ≤ 1` in steady state; `DEPTH` sizes for future multi-cycle stalls and must still be honoured.

## Configuration
- `WBQ_BYPASS_EN` defined: forwarding lookup logic is compiled in as described.
- Not defined:
  - `RsHit=RtHit=0` and `RsFwd=RtFwd=0` constantly.
  - No search logic is synthesized.
  - Queue behaviour is identical.

## Test plan
- Reset, then A writes r5=0x12345678 → `RegWrite=1`, `RdAddr=5`, `RdData=0x12345678` exactly one cycle after acceptance; `Count` returns to 0.
- `AValid` and `BValid` both high (r1=0xA, r2=0xB) → `BReady=0`. A commits first; B is accepted the next cycle and commits after A.
- A writes r0=0xFFFFFFFF → handshake completes, `Count` stays 0, `RegWrite` never asserts.
- A writes r7=0x1, then r7=0x2 back-to-back, `RsAddr=7`:
  - With `WBQ_BYPASS_EN`: `RsHit=1`, `RsFwd=0x2` while both are pending; then `0x2` from the output stage.
  - Without the macro: `RsHit=0`.
- Assert `nReset` while `RegWrite=1` (r3=0x9) → `RegWrite`, `RdAddr`, `RdData` and `Count` go to 0 immediately; no write is issued after release.

Source files
------------

// File: rtl/writeback_queue.sv
// Register-file writeback queue: two producers (A has priority) feed a circular
// FIFO that drains one write per cycle. Optional forwarding search under WBQ_BYPASS_EN.
module writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       Clock,
  input  logic                       nReset,
  input  logic                       AValid,
  output logic                       AReady,
  input  logic [4:0]                 AAddr,
  input  logic [31:0]                AData,
  input  logic                       BValid,
  output logic                       BReady,
  input  logic [4:0]                 BAddr,
  input  logic [31:0]                BData,
  output logic                       RegWrite,
  output logic [4:0]                 RdAddr,
  output logic [31:0]                RdData,
  input  logic [4:0]                 RsAddr,
  input  logic [4:0]                 RtAddr,
  output logic                       RsHit,
  output logic [31:0]                RsFwd,
  output logic                       RtHit,
  output logic [31:0]                RtFwd,
  output logic [$clog2(DEPTH+1)-1:0] Count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_req_t;

  wb_req_t       mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic          a_acc, b_acc, push, pop;
  wb_req_t       in_req, head_req;

  // Readiness looks only at the current Count; a same-edge pop never frees a slot.
  assign AReady   = (Count != FULL);
  assign BReady   = (Count != FULL) & ~AValid;
  assign a_acc    = AValid & AReady;
  assign b_acc    = BValid & BReady;
  assign in_req   = a_acc ? '{addr: AAddr, data: AData} : '{addr: BAddr, data: BData};
  // r0 writes complete the handshake but are dropped here.
  assign push     = (a_acc | b_acc) && (in_req.addr != 5'd0);
  assign pop      = (Count != '0);
  assign head_req = mem[head];

  always_ff @(posedge Clock) begin
    if (push) mem[tail] <= in_req;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      head     <= '0;
      tail     <= '0;
      Count    <= '0;
      RegWrite <= 1'b0;
      RdAddr   <= '0;
      RdData   <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   Count <= Count + 1'b1;
        2'b01:   Count <= Count - 1'b1;
        default: ;
      endcase
      RegWrite <= pop;
      if (pop) begin
        RdAddr <= head_req.addr;
        RdData <= head_req.data;
      end
    end
  end

`ifdef WBQ_BYPASS_EN
  // Output stage is the oldest candidate; walking queue entries oldest to
  // youngest lets the youngest match overwrite earlier ones.
  always_comb begin
    logic [PW-1:0] idx;
    idx   = '0;
    RsHit = RegWrite && (RsAddr != 5'd0) && (RdAddr == RsAddr);
    RsFwd = RsHit ? RdData : '0;
    RtHit = RegWrite && (RtAddr != 5'd0) && (RdAddr == RtAddr);
    RtFwd = RtHit ? RdData : '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < Count) begin
        if ((RsAddr != 5'd0) && (mem[idx].addr == RsAddr)) begin
          RsHit = 1'b1;
          RsFwd = mem[idx].data;
        end
        if ((RtAddr != 5'd0) && (mem[idx].addr == RtAddr)) begin
          RtHit = 1'b1;
          RtFwd = mem[idx].data;
        end
      end
    end
  end
`else
  logic unused_lookup;
  assign unused_lookup = ^{RsAddr, RtAddr};
  assign RsHit = 1'b0;
  assign RsFwd = '0;
  assign RtHit = 1'b0;
  assign RtFwd = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed plus random stimulus for writeback_queue, checked against a
// queue-of-pending-writes reference model.
module tb_writeback_queue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          Clock = 1'b0;
  logic          nReset;
  logic          AValid, BValid, AReady, BReady;
  logic [4:0]    AAddr, BAddr, RdAddr, RsAddr, RtAddr;
  logic [31:0]   AData, BData, RdData, RsFwd, RtFwd;
  logic          RegWrite, RsHit, RtHit;
  logic [CW-1:0] Count;

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .Clock(Clock), .nReset(nReset),
    .AValid(AValid), .AReady(AReady), .AAddr(AAddr), .AData(AData),
    .BValid(BValid), .BReady(BReady), .BAddr(BAddr), .BData(BData),
    .RegWrite(RegWrite), .RdAddr(RdAddr), .RdData(RdData),
    .RsAddr(RsAddr), .RtAddr(RtAddr),
    .RsHit(RsHit), .RsFwd(RsFwd), .RtHit(RtHit), .RtFwd(RtFwd),
    .Count(Count)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  // Reference: pending writes in acceptance order, plus the register-file port.
  wr_t         pend[$];
  logic        ow;
  logic [4:0]  oa;
  logic [31:0] od;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] look(input logic [4:0] a);
    if (a != 5'd0) begin
`ifdef WBQ_BYPASS_EN
      for (int i = pend.size() - 1; i >= 0; i--)
        if (pend[i].a == a) return {1'b1, pend[i].d};
      if (ow && oa == a) return {1'b1, od};
`endif
    end
    return '0;
  endfunction

  task automatic model_check();
    logic [32:0] r;
    chk("count",    32'(Count), pend.size());
    chk("aready",   AReady,   pend.size() != DEPTH);
    chk("bready",   BReady,   (pend.size() != DEPTH) && !AValid);
    chk("regwrite", RegWrite, ow);
    chk("rdaddr",   RdAddr,   oa);
    chk("rddata",   RdData,   od);
    r = look(RsAddr);
    chk("rshit", RsHit, r[32]);
    chk("rsfwd", RsFwd, r[31:0]);
    r = look(RtAddr);
    chk("rthit", RtHit, r[32]);
    chk("rtfwd", RtFwd, r[31:0]);
  endtask

  task automatic step(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                      input bit bv, input logic [4:0] ba, input logic [31:0] bd);
    bit  acc_a, acc_b;
    wr_t w, h;
    AValid = av; AAddr = aa; AData = ad;
    BValid = bv; BAddr = ba; BData = bd;
    #1;
    model_check();
    acc_a = av && (pend.size() != DEPTH);
    acc_b = bv && !av && (pend.size() != DEPTH);
    w.a = acc_a ? aa : ba;
    w.d = acc_a ? ad : bd;
    @(posedge Clock);
    if (pend.size() > 0) begin
      h  = pend.pop_front();
      ow = 1'b1; oa = h.a; od = h.d;
    end else begin
      ow = 1'b0;
    end
    if ((acc_a || acc_b) && w.a != 5'd0) pend.push_back(w);
    #1;
  endtask

  initial begin
    nReset = 1'b0;
    AValid = 0; AAddr = 0; AData = 0;
    BValid = 0; BAddr = 0; BData = 0;
    RsAddr = 0; RtAddr = 0;
    ow = 0; oa = 0; od = 0;
    #2;
    chk("rst_count", 32'(Count), 0);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_rdaddr", RdAddr, 0);
    chk("rst_rddata", RdData, 0);
    chk("rst_aready", AReady, 1);
    chk("rst_bready", BReady, 1);
    AValid = 1'b1;
    #1;
    chk("rst_bready_av", BReady, 0);
    AValid = 1'b0;
    @(posedge Clock); #1;
    nReset = 1'b1;

    // single write latency
    RsAddr = 5; RtAddr = 0;
    step(1, 5, 32'h12345678, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t1_regwrite", RegWrite, 1);
    chk("t1_rdaddr", RdAddr, 5);
    chk("t1_rddata", RdData, 32'h12345678);
    chk("t1_count", 32'(Count), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t1_regwrite_off", RegWrite, 0);

    // A priority over B
    RsAddr = 1; RtAddr = 2;
    step(1, 1, 32'hA, 1, 2, 32'hB);
    step(0, 0, 0, 1, 2, 32'hB);
    chk("t2_first", RdAddr, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("t2_second", RdAddr, 2);
    chk("t2_second_d", RdData, 32'hB);
    step(0, 0, 0, 0, 0, 0);

    // r0 filtering
    step(1, 0, 32'hFFFFFFFF, 0, 0, 0);
    chk("t3_count", 32'(Count), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t3_regwrite", RegWrite, 0);

    // same-register writes, youngest forwarded
    RsAddr = 7; RtAddr = 0;
    step(1, 7, 32'h1, 0, 0, 0);
    step(1, 7, 32'h2, 0, 0, 0);
`ifdef WBQ_BYPASS_EN
    chk("t4_hit_q", RsHit, 1);
    chk("t4_fwd_q", RsFwd, 32'h2);
`else
    chk("t4_hit_q", RsHit, 0);
`endif
    step(0, 0, 0, 0, 0, 0);
`ifdef WBQ_BYPASS_EN
    chk("t4_fwd_out", RsFwd, 32'h2);
`else
    chk("t4_hit_out", RsHit, 0);
`endif
    chk("t4_commit", RdData, 32'h2);
    step(0, 0, 0, 0, 0, 0);

    // reset while a write is on the port and another is pending
    RsAddr = 3; RtAddr = 4;
    step(1, 3, 32'h9, 0, 0, 0);
    step(1, 4, 32'h44, 0, 0, 0);
    chk("t5_pre_regwrite", RegWrite, 1);
    AValid = 0; AAddr = 0; AData = 0;
    nReset = 1'b0;
    #1;
    chk("t5_regwrite", RegWrite, 0);
    chk("t5_rdaddr", RdAddr, 0);
    chk("t5_rddata", RdData, 0);
    chk("t5_count", 32'(Count), 0);
    pend.delete();
    ow = 0; oa = 0; od = 0;
    model_check();
    #2;
    nReset = 1'b1;
    @(posedge Clock); #1;
    repeat (3) step(0, 0, 0, 0, 0, 0);

    // random traffic
    repeat (300) begin
      RsAddr = 5'($urandom_range(0, 7));
      RtAddr = 5'($urandom_range(0, 7));
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    end
    repeat (3) step(0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
